uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart of the 8x-oversampled receive path.
- Accepts a parallel byte through a valid/busy handshake and serialises it LSB-first on TX_OUT.
- Frame: start bit, 8 data bits, optional parity bit, one stop bit.
- Each bit is held for PRESCALE clocks, so TX bit timing matches the receiver's oversampling ratio.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE, 8, CLK cycles per transmitted bit (legal: 4, 8, 16, 32).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- P_DATA  in  DATA_WIDTH  byte to send; sampled only on acceptance.
- DATA_VALID  in  1  request; accepted when high while BUSY low.
- PAR_EN  in  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on acceptance.
- TX_OUT  out  1  serial line; idle high.
- BUSY  out  1  high from the first start-bit cycle through the last stop-bit cycle.

Behaviour:
- Reset (RST low, asynchronous): TX_OUT=1, BUSY=0, state=IDLE; bit counter, prescale counter, shift register and latched parity configuration all cleared. Applies immediately, including mid-frame; no partial-frame completion.
- Acceptance: on a rising edge with state=IDLE and DATA_VALID=1:
  - latch P_DATA, PAR_EN, PAR_TYP and parity bit (even: XOR-reduce of data; odd: its inverse);
  - next cycle: state=START, TX_OUT=0, BUSY=1.
  - Latency from acceptance edge to the start-bit line change: one clock.
- DATA_VALID while BUSY=1 is ignored; no queuing. P_DATA changes after acceptance do not affect the frame.
- FSM states and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA after PRESCALE cycles.
  - DATA holds bit i (i=0..DATA_WIDTH-1, LSB first) for PRESCALE cycles each. After bit DATA_WIDTH-1: -> PARITY if latched PAR_EN=1, else -> STOP.
  - PARITY holds the parity bit for PRESCALE cycles, then -> STOP.
  - STOP drives 1 for PRESCALE cycles, then -> IDLE with BUSY=0 on the same edge.
- Prescale counter: counts 0..PRESCALE-1 and wraps to 0 on each bit boundary. Bit counter: 0..DATA_WIDTH-1, cleared on entry to DATA.
- TX_OUT is registered (glitch-free). Value by state: 1 in IDLE and STOP, 0 in START.
- Frame length with BUSY high: (2 + DATA_WIDTH + PAR_EN) * PRESCALE cycles. Default 80 without parity, 88 with parity.
- Back-to-back frames: BUSY falls at the STOP->IDLE edge. The earliest next acceptance is on the following edge, giving at least one idle-high cycle between frames.
- DATA_VALID high continuously: frames repeat with exactly one IDLE cycle between them.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN=0 and PAR_ODD=1 constants;
  - default PRESCALE and DATA_WIDTH constants, shared with the receive path.
- One natural sub-module: uart_tx_serializer, containing the shift register, bit counter and done flag, driven by a bit-tick from the top-level prescaler/FSM.

Test Plan:
- Reset then idle, DATA_VALID=0: TX_OUT=1 and BUSY=0 for 100 cycles.
- P_DATA=0xA5, PAR_EN=0, PRESCALE=8: TX_OUT low for 8 cycles, then 1,0,1,0,0,1,0,1 for 8 cycles each, then high for 8 cycles; BUSY high exactly 80 cycles.
- P_DATA=0xA5, PAR_EN=1:
  - PAR_TYP=0: parity bit 0, BUSY high 88 cycles.
  - repeated with PAR_TYP=1: parity bit 1.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=1: parity bit 0. P_DATA changed to 0xFF and DATA_VALID pulsed mid-frame: frame still carries 0x01 and no second frame starts.
- DATA_VALID held high with 0x3C then 0xC3: two complete frames, exactly one idle-high cycle between them, and the receive deserializer loopback recovers 0x3C then 0xC3.
- RST asserted low during data bit 4 of 0x5A: TX_OUT=1 and BUSY=0 asynchronously. After release, a new 0x81 frame transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants for the transmit and receive paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PRESCALE   = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module      : uart_tx_serializer
// Description : LSB-first shift register and bit counter, advanced by a bit tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic                  o_bit_cur,
    output logic                  o_bit_next,
    output logic                  o_done
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (i_load) begin
            shreg_d   = i_data;
            bit_cnt_d = '0;
        end else if (i_shift) begin
            shreg_d   = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The next bit is exposed so the top can register the line one edge early.
    assign o_bit_cur  = shreg_q[0];
    assign o_bit_next = shreg_q[1];
    assign o_done     = (bit_cnt_q == C_BIT_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter: start, LSB-first data, optional parity, stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE   = DEFAULT_PRESCALE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PRESCALE - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic w_accept;
    logic w_bit_tick;
    logic w_bit_cur;
    logic w_bit_next;
    logic w_ser_done;

    assign w_accept   = (state_q == ST_IDLE) && DATA_VALID;
    assign w_bit_tick = (state_q != ST_IDLE) && (cnt_q == C_CNT_LAST);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk        (CLK),
        .rst_n      (RST),
        .i_load     (w_accept),
        .i_data     (P_DATA),
        .i_shift    (w_bit_tick && (state_q == ST_DATA)),
        .o_bit_cur  (w_bit_cur),
        .o_bit_next (w_bit_next),
        .o_done     (w_ser_done)
    );

    // Line value is decided on the transition edge so TX_OUT comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        cnt_d     = (state_q == ST_IDLE || w_bit_tick) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    state_d = ST_DATA;
                    tx_d    = w_bit_cur;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    if (!w_ser_done) begin
                        tx_d = w_bit_next;
                    end else if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Directed self-checking bench for uart_tx_frame (PRESCALE = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    uart_tx_frame #(
        .DATA_WIDTH (8),
        .PRESCALE   (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Records TX_OUT on each falling edge while BUSY is high; bit k is taken from
    // the first cycle of its 8-cycle slot and the rest of the slot must match it.
    task automatic capture_frame(output logic [15:0] bits, output int busy_cycles,
                                 output int unstable);
        logic line [0:255];
        int   n;
        n = 0;
        bits = '0;
        unstable = 0;
        while (BUSY === 1'b1 && n < 250) begin
            line[n] = TX_OUT;
            n++;
            @(negedge CLK);
        end
        busy_cycles = n;
        for (int b = 0; b < 16; b++) begin
            if (b * 8 + 7 < n) begin
                bits[b] = line[b * 8];
                for (int c = 1; c < 8; c++)
                    if (line[b * 8 + c] !== line[b * 8]) unstable++;
            end
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp);
        @(negedge CLK);
        P_DATA = d;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: TX_OUT=%b BUSY=%b, required TX_OUT=1 BUSY=0", TX_OUT, BUSY);
        end
        RST = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            checks++;
            if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle_%0d: TX_OUT=%b BUSY=%b, required 1/0", i, TX_OUT, BUSY);
            end
        end
    endtask

    task automatic test_no_parity;
        logic [15:0] bits;
        int busy_n, unst;
        start_frame(8'hA5, 1'b0, 1'b0);
        capture_frame(bits, busy_n, unst);
        checks++;
        if (busy_n !== 80) begin
            errors++;
            $display("FAIL a5_busy_len: got %0d cycles, required 80", busy_n);
        end
        checks++;
        if (bits[9:0] !== 10'b1_10100101_0) begin
            errors++;
            $display("FAIL a5_bits: got %b, required %b", bits[9:0], 10'b1_10100101_0);
        end
        checks++;
        if (unst !== 0) begin
            errors++;
            $display("FAIL a5_bit_hold: %0d unstable cycles, required 0", unst);
        end
        checks++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL a5_after: TX_OUT=%b BUSY=%b, required 1/0", TX_OUT, BUSY);
        end
    endtask

    task automatic test_parity;
        logic [15:0] bits;
        int busy_n, unst;
        start_frame(8'hA5, 1'b1, 1'b0);
        capture_frame(bits, busy_n, unst);
        checks++;
        if (busy_n !== 88) begin
            errors++;
            $display("FAIL even_busy_len: got %0d cycles, required 88", busy_n);
        end
        checks++;
        if (bits[10:0] !== 11'b1_0_10100101_0 || unst !== 0) begin
            errors++;
            $display("FAIL even_bits: got %b (unstable %0d), required %b", bits[10:0], unst, 11'b1_0_10100101_0);
        end
        repeat (3) @(negedge CLK);
        start_frame(8'hA5, 1'b1, 1'b1);
        capture_frame(bits, busy_n, unst);
        checks++;
        if (busy_n !== 88) begin
            errors++;
            $display("FAIL odd_busy_len: got %0d cycles, required 88", busy_n);
        end
        checks++;
        if (bits[10:0] !== 11'b1_1_10100101_0 || unst !== 0) begin
            errors++;
            $display("FAIL odd_bits: got %b (unstable %0d), required %b", bits[10:0], unst, 11'b1_1_10100101_0);
        end
    endtask

    task automatic test_ignore_midframe;
        logic [15:0] bits;
        int busy_n, unst;
        int extra;
        start_frame(8'h01, 1'b1, 1'b1);
        fork
            capture_frame(bits, busy_n, unst);
            begin
                repeat (30) @(negedge CLK);
                P_DATA = 8'hFF;
                DATA_VALID = 1'b1;
                @(negedge CLK);
                DATA_VALID = 1'b0;
            end
        join
        checks++;
        if (bits[10:0] !== 11'b1_0_00000001_0 || busy_n !== 88 || unst !== 0) begin
            errors++;
            $display("FAIL midframe_bits: got %b len %0d unstable %0d, required %b len 88",
                     bits[10:0], busy_n, unst, 11'b1_0_00000001_0);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (BUSY !== 1'b0 || TX_OUT !== 1'b1) extra++;
            @(negedge CLK);
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL midframe_no_second: %0d non-idle cycles, required 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] bits1, bits2;
        int busy1, busy2, unst1, unst2, idle_n;
        logic idle_line_bad;
        @(negedge CLK);
        P_DATA = 8'h3C;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        capture_frame(bits1, busy1, unst1);
        P_DATA = 8'hC3;
        idle_n = 0;
        idle_line_bad = 1'b0;
        while (BUSY !== 1'b1 && idle_n < 20) begin
            if (TX_OUT !== 1'b1) idle_line_bad = 1'b1;
            idle_n++;
            @(negedge CLK);
        end
        capture_frame(bits2, busy2, unst2);
        DATA_VALID = 1'b0;
        checks++;
        if (idle_n !== 1 || idle_line_bad !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles (line_low=%b), required 1 high", idle_n, idle_line_bad);
        end
        checks++;
        if (bits1[8:1] !== 8'h3C || bits1[0] !== 1'b0 || bits1[9] !== 1'b1 || busy1 !== 80 || unst1 !== 0) begin
            errors++;
            $display("FAIL b2b_frame1: recovered %h bits %b len %0d, required 3c len 80", bits1[8:1], bits1[9:0], busy1);
        end
        checks++;
        if (bits2[8:1] !== 8'hC3 || bits2[0] !== 1'b0 || bits2[9] !== 1'b1 || busy2 !== 80 || unst2 !== 0) begin
            errors++;
            $display("FAIL b2b_frame2: recovered %h bits %b len %0d, required c3 len 80", bits2[8:1], bits2[9:0], busy2);
        end
        repeat (5) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: BUSY=%b, required 0", BUSY);
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] bits;
        int busy_n, unst;
        start_frame(8'h5A, 1'b0, 1'b0);
        repeat (42) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1 || TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bit4: TX_OUT=%b BUSY=%b, required 1/1", TX_OUT, BUSY);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: TX_OUT=%b BUSY=%b, required 1/0", TX_OUT, BUSY);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        start_frame(8'h81, 1'b0, 1'b0);
        capture_frame(bits, busy_n, unst);
        checks++;
        if (bits[9:0] !== 10'b1_10000001_0 || busy_n !== 80 || unst !== 0) begin
            errors++;
            $display("FAIL post_reset_81: got %b len %0d unstable %0d, required %b len 80",
                     bits[9:0], busy_n, unst, 10'b1_10000001_0);
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
